// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer and its button debouncer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STRETCH   = 2'd1,
    S_RUN       = 2'd2,
    S_BTN       = 2'd3
  } reset_seq_state_t;

  // Idle values of the synchronizer chains: PLL reads unlocked, button reads released.
  localparam logic LOCK_SYNC_RESET = 1'b0;
  localparam logic BTN_SYNC_RESET  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Board-facing signal bundle of the reset sequencer.
// Watchdog kick/fired signals only exist when RESET_SEQ_WDT_EN is defined.
interface reset_sequencer_if;
  logic clk_locked_i;
  logic btn_ni;
  logic reset_o;
  logic locked_o;
  logic btn_event_o;
`ifdef RESET_SEQ_WDT_EN
  logic wdt_kick_i;
  logic wdt_fired_o;

  modport master (output clk_locked_i, btn_ni, wdt_kick_i,
                  input  reset_o, locked_o, btn_event_o, wdt_fired_o);
  modport slave  (input  clk_locked_i, btn_ni, wdt_kick_i,
                  output reset_o, locked_o, btn_event_o, wdt_fired_o);
`else
  modport master (output clk_locked_i, btn_ni,
                  input  reset_o, locked_o, btn_event_o);
  modport slave  (input  clk_locked_i, btn_ni,
                  output reset_o, locked_o, btn_event_o);
`endif
endinterface

// File: rtl/reset_sequencer_debounce.sv
// Synchronizer plus debouncer for one asynchronous, bouncy input.
// The level only changes after DEBOUNCE_CYCLES consecutive disagreeing samples.
module debounce
  import reset_sequencer_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 120000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic raw_i,
  output logic level_o,
  output logic fall_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   fall_q, fall_d;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;
  assign fall_o  = fall_q;

  // Plain flop chain bringing the raw input into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset_ni) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  // Count disagreeing samples; flip the level on the last one, restart on any agreement.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) level_d = synced;
      else                   cnt_d   = cnt_q + 1'b1;
    end
    fall_d = level_q & ~level_d;
  end

  // Debounce state and the registered falling-edge pulse.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset sequencer: waits for PLL lock, stretches reset, holds reset while the
// debounced button is pressed and re-enters reset on lock loss.
// Optional watchdog enabled by defining RESET_SEQ_WDT_EN.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int RESET_CYCLES    = 31
`ifdef RESET_SEQ_WDT_EN
  , parameter int WDT_CYCLES    = 12000000
`endif
) (
  input  logic               clk,
  input  logic               reset_ni,
  reset_sequencer_if.slave   bus
);

  localparam int            SW           = cnt_width(RESET_CYCLES + 1);
  localparam logic [SW-1:0] STRETCH_LAST = SW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STRETCH_MAX  = '1;

  reset_seq_state_t       state_q, state_d;
  logic [SW-1:0]          stretch_q, stretch_d;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   locked;
  logic                   btn_level;
  logic                   btn_fall;
  logic                   reset_q;

`ifdef RESET_SEQ_WDT_EN
  localparam int            WW       = cnt_width(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
  localparam logic [WW-1:0] WDT_MAX  = '1;

  logic [WW-1:0] wdt_q, wdt_d;
  logic          wdt_fired_q, wdt_fired_d;
`endif

  assign locked          = lock_sync_q[SYNC_STAGES-1];
  assign bus.locked_o    = locked;
  assign bus.reset_o     = reset_q;
  assign bus.btn_event_o = btn_fall;

  debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_LEVEL    (BTN_SYNC_RESET)
  ) u_btn (
    .clk     (clk),
    .reset_ni(reset_ni),
    .raw_i   (bus.btn_ni),
    .level_o (btn_level),
    .fall_o  (btn_fall)
  );

  // PLL lock synchronizer; lock is trusted only after the full chain.
  always_ff @(posedge clk) begin
    if (!reset_ni) lock_sync_q <= {SYNC_STAGES{LOCK_SYNC_RESET}};
    else           lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.clk_locked_i};
  end

  // Sequencing decisions: lock loss beats a press, a press beats the counters.
  always_comb begin
    state_d   = state_q;
    stretch_d = '0;
`ifdef RESET_SEQ_WDT_EN
    wdt_d       = '0;
    wdt_fired_d = wdt_fired_q;
`endif
    case (state_q)
      S_WAIT_LOCK: begin
        if (locked) state_d = S_STRETCH;
      end
      S_STRETCH: begin
        if (!locked)                        state_d = S_WAIT_LOCK;
        else if (!btn_level)                state_d = S_BTN;
        else if (stretch_q == STRETCH_LAST) state_d = S_RUN;
        else stretch_d = (stretch_q == STRETCH_MAX) ? stretch_q : stretch_q + 1'b1;
      end
      S_RUN: begin
        if (!locked)         state_d = S_WAIT_LOCK;
        else if (!btn_level) state_d = S_BTN;
`ifdef RESET_SEQ_WDT_EN
        else if (bus.wdt_kick_i) wdt_d = '0;
        else if (wdt_q == WDT_LAST) begin
          state_d     = S_STRETCH;
          wdt_fired_d = 1'b1;
        end
        else wdt_d = (wdt_q == WDT_MAX) ? wdt_q : wdt_q + 1'b1;
`endif
      end
      S_BTN: begin
        if (!locked)        state_d = S_WAIT_LOCK;
        else if (btn_level) state_d = S_STRETCH;
      end
      default: state_d = S_WAIT_LOCK;
    endcase
  end

  // State, stretch counter and the reset output taken straight from the next state.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      state_q   <= S_WAIT_LOCK;
      stretch_q <= '0;
      reset_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      stretch_q <= stretch_d;
      reset_q   <= (state_d != S_RUN);
    end
  end

`ifdef RESET_SEQ_WDT_EN
  assign bus.wdt_fired_o = wdt_fired_q;

  // Watchdog counter and sticky fired flag; only reset_ni clears the flag.
  always_ff @(posedge clk) begin
    if (!reset_ni) begin
      wdt_q       <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_q       <= wdt_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: power-up vector table, hand-written corner
// sequences and a randomized phase, all checked against a run-length model.
// Define RESET_SEQ_WDT_EN to include the watchdog sequence.
module tb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int RC   = 4;
`ifdef RESET_SEQ_WDT_EN
  localparam int WDT  = 20;
`endif

  typedef struct packed {
    logic rstN;
    logic lock;
    logic btn;
    logic expReset;
    logic expLocked;
    logic expEvent;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cycleNo = 0;
  vec_t vecs [20];

  reset_sequencer_if bus_if ();

  reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_CYCLES   (RC)
`ifdef RESET_SEQ_WDT_EN
    , .WDT_CYCLES   (WDT)
`endif
  ) dut (
    .clk     (clk),
    .reset_ni(reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: input histories, a sliding debounce window, and reset
  // released once RC+1 consecutive "good" edges have been seen.
  bit lockQ [$];
  bit btnQ  [$];
  bit winQ  [$];
  bit mLevel, mPrevL, mFired, mL, mB, mSynced, mFlip, mAllDiff, mFire;
  int mRun, mIdle;
  logic expReset, expLocked, expEvent, expFired;

  always @(posedge clk) begin
    if (!reset_n) begin
      lockQ.delete(); btnQ.delete(); winQ.delete();
      for (int i = 0; i < SYNC; i++) begin
        lockQ.push_back(1'b0);
        btnQ.push_back(1'b1);
      end
      mLevel = 1'b1; mPrevL = 1'b0; mFired = 1'b0; mRun = 0; mIdle = 0;
      expReset = 1'b1; expLocked = 1'b0; expEvent = 1'b0; expFired = 1'b0;
    end else begin
      mL      = lockQ[0];
      mSynced = btnQ[0];
      lockQ.push_back(bus_if.clk_locked_i); lockQ.delete(0);
      btnQ.push_back(bus_if.btn_ni);        btnQ.delete(0);
      mB = mLevel;
      winQ.push_back(mSynced);
      if (winQ.size() > DEB) winQ.delete(0);
      mFlip = 1'b0;
      if (winQ.size() == DEB) begin
        mAllDiff = 1'b1;
        foreach (winQ[i]) if (winQ[i] == mLevel) mAllDiff = 1'b0;
        if (mAllDiff) begin
          mLevel = ~mLevel;
          mFlip  = 1'b1;
        end
      end
      mFire = 1'b0;
`ifdef RESET_SEQ_WDT_EN
      if (mRun >= RC + 1 && mL && mB) begin
        if (bus_if.wdt_kick_i) mIdle = 0;
        else if (mIdle == WDT - 1) begin
          mFire = 1'b1; mIdle = 0; mFired = 1'b1;
        end else mIdle++;
      end else mIdle = 0;
`endif
      if (mFire) mRun = 1;
      else if (mL && (mB || !mPrevL)) begin
        if (mRun < 1000) mRun++;
      end else mRun = 0;
      mPrevL    = mL;
      expLocked = lockQ[0];
      expEvent  = mFlip && !mLevel;
      expReset  = (mRun < RC + 1);
      expFired  = mFired;
    end
  end

  task automatic applyStimulus(input logic rstN, input logic lock, input logic btn);
    reset_n = rstN;
    bus_if.clk_locked_i = lock;
    bus_if.btn_ni = btn;
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] act, want;
    logic firedAct;
`ifdef RESET_SEQ_WDT_EN
    firedAct = bus_if.wdt_fired_o;
`else
    firedAct = 1'b0;
`endif
    act  = {bus_if.reset_o, bus_if.locked_o, bus_if.btn_event_o, firedAct};
    want = {expReset, expLocked, expEvent, expFired};
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: reset/locked/event/fired got %b want %b", tag, cycleNo, act, want);
    end
  endtask

  task automatic checkValue(input string tag, input logic act, input logic want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %b want %b", tag, cycleNo, act, want);
    end
  endtask

  task automatic checkVector(input int i);
    logic [2:0] act, want;
    act  = {bus_if.reset_o, bus_if.locked_o, bus_if.btn_event_o};
    want = {vecs[i].expReset, vecs[i].expLocked, vecs[i].expEvent};
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL powerup edge %0d: reset/locked/event got %b want %b", i + 1, act, want);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    cycleNo++;
    checkOutput(tag);
  endtask

  int   eventCount, lowCount, highCount;
  int   lockHold = 0, btnHold = 0;
  logic lockVal = 1'b1, btnVal = 1'b1, rstVal;

  initial begin
    for (int n = 1; n <= 20; n++) begin
      vecs[n-1] = '{rstN: (n > 3), lock: (n >= 11), btn: 1'b1,
                    expReset: (n < 17), expLocked: (n >= 12), expEvent: 1'b0};
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
`ifdef RESET_SEQ_WDT_EN
    bus_if.wdt_kick_i = 1'b1;
`endif

    // Power-up: reset, lock after edge 10, reset_o falls at edge 17.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].lock, vecs[i].btn);
      tick("powerup model");
      checkVector(i);
    end

    // Bounce: three 5-cycle low glitches in RUN must be ignored.
    eventCount = 0; highCount = 0;
    for (int t = 0; t < 40; t++) begin
      applyStimulus(1'b1, 1'b1, (t < 30 && (t % 10) < 5) ? 1'b0 : 1'b1);
      tick("bounce");
      if (bus_if.btn_event_o) eventCount++;
      if (bus_if.reset_o) highCount++;
    end
    checkValue("bounce no event", (eventCount != 0), 1'b0);
    checkValue("bounce no reset", (highCount != 0), 1'b0);

    // Clean press: 20 low cycles, then release and re-stretch.
    eventCount = 0;
    for (int t = 1; t <= 40; t++) begin
      applyStimulus(1'b1, 1'b1, (t <= 20) ? 1'b0 : 1'b1);
      tick("press");
      if (bus_if.btn_event_o) eventCount++;
      if (t == 10) checkValue("press event timing", bus_if.btn_event_o, 1'b1);
      if (t == 34) checkValue("press stretch high", bus_if.reset_o, 1'b1);
      if (t == 35) checkValue("press run low", bus_if.reset_o, 1'b0);
    end
    checkValue("press single event", (eventCount == 1), 1'b1);

    // Lock loss for one cycle during RUN, then re-sequence.
    for (int t = 1; t <= 10; t++) begin
      applyStimulus(1'b1, (t == 1) ? 1'b0 : 1'b1, 1'b1);
      tick("lockloss");
      if (t == 3) checkValue("lockloss reset high", bus_if.reset_o, 1'b1);
      if (t == 7) checkValue("lockloss still high", bus_if.reset_o, 1'b1);
      if (t == 8) checkValue("lockloss reset low", bus_if.reset_o, 1'b0);
    end

    // Lock loss while held in S_BTN; reset must stay high until release.
    for (int t = 0; t < 15; t++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick("btn hold");
    end
    lowCount = 0;
    for (int t = 0; t < 18; t++) begin
      applyStimulus(1'b1, (t < 3) ? 1'b0 : 1'b1, 1'b0);
      tick("btn lockloss");
      if (!bus_if.reset_o) lowCount++;
    end
    checkValue("btn lockloss held", (lowCount == 0), 1'b1);
    for (int t = 1; t <= 16; t++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick("btn release");
      if (t == 14) checkValue("release stretch high", bus_if.reset_o, 1'b1);
    end
    checkValue("release run low", bus_if.reset_o, 1'b0);

`ifdef RESET_SEQ_WDT_EN
    // Watchdog: no kicks fires it, periodic kicks keep RUN, reset_ni clears flag.
    bus_if.wdt_kick_i = 1'b0;
    for (int t = 1; t <= 22; t++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick("wdt starve");
      if (t == 19) checkValue("wdt before fire", bus_if.reset_o, 1'b0);
    end
    checkValue("wdt reset high", bus_if.reset_o, 1'b1);
    checkValue("wdt fired set", bus_if.wdt_fired_o, 1'b1);
    highCount = 0;
    for (int t = 0; t < 60; t++) begin
      bus_if.wdt_kick_i = ((t % 10) == 0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      tick("wdt kicked");
      if (t >= 5 && bus_if.reset_o) highCount++;
    end
    checkValue("wdt kicks hold run", (highCount == 0), 1'b1);
    checkValue("wdt fired sticky", bus_if.wdt_fired_o, 1'b1);
    bus_if.wdt_kick_i = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1);
    tick("wdt clear");
    checkValue("wdt fired cleared", bus_if.wdt_fired_o, 1'b0);
`endif

    // Randomized phase against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if (lockHold == 0) begin
        lockVal  = ($urandom_range(0, 99) < 85);
        lockHold = lockVal ? $urandom_range(20, 150) : $urandom_range(1, 6);
      end
      lockHold--;
      if (btnHold == 0) begin
        btnVal  = ($urandom_range(0, 99) < 65);
        btnHold = $urandom_range(1, 25);
      end
      btnHold--;
      rstVal = ($urandom_range(0, 599) != 0);
`ifdef RESET_SEQ_WDT_EN
      bus_if.wdt_kick_i = ($urandom_range(0, 14) == 0);
`endif
      applyStimulus(rstVal, lockVal, btnVal);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
